background_model_ema: RTL
=========================

// Module: background_model_ema
// PURPOSE
//  Streaming per-pixel background model, successor to the frame-batch mean/SD model.
//  Keeps a running exponential-moving-average mean and variance per pixel per channel.
//  Memory is RAM-style, one word per pixel. Flags each pixel foreground/background.
//  Sits between the camera pixel stream and the motion/blob stage.
// PARAMETERS
//  WIDTH          320  frame width in pixels
//  HEIGHT         240  frame height; WIDTH*HEIGHT >= 4 (elaboration assertion)
//  NUM_CH         3    colour channels, 8-bit unsigned each
//  FRAC           8    fractional bits; mean Q8.FRAC (MW=8+FRAC), var Q16.FRAC (VW=16+FRAC)
//  ALPHA_SHIFT    3    learning rate = 2^-ALPHA_SHIFT
//  K_SQ           9    integer threshold^2: fg when d^2 > K_SQ*var
//  VAR_INIT       4096 variance seeded on INIT (Q16.FRAC; 16.0)
//  VAR_MIN        256  variance floor (Q16.FRAC; 1.0)
//  WARMUP_FRAMES  1    learn frames after INIT with fg forced 0
// PORTS
//  clk        in   1            clock
//  rst        in   1            synchronous active-high reset
//  pix_valid  in   1            input pixel valid
//  pix_ready  out  1            pipeline accepts pixel (= advance)
//  pix_data   in   NUM_CH*8     channel c at [8c+7:8c]
//  pix_sof    in   1            first pixel of frame, qualified by pix_valid
//  mode       in   2            0 LEARN, 1 FREEZE, 2 INIT, 3 reserved (=LEARN)
//  clear      in   1            pulse: next frame forced INIT, warm-up restarts
//  out_valid  out  1            result valid
//  out_ready  in   1            downstream accepts result
//  out_mean   out  NUM_CH*MW    post-update mean, Q8.FRAC per channel
//  out_var    out  NUM_CH*VW    post-update variance, Q16.FRAC per channel
//  out_fg     out  1            OR over channels of fg_c, pre-update model
//  out_idx    out  clog2(W*H)   pixel index of result
//  sync_err   out  1            sticky: pix_sof seen at idx!=0; cleared only by rst
// BEHAVIOUR
//  - Reset values: out_valid 0, out_* 0, sync_err 0, idx 0, warm-up counter 0,
//    init_pending 1 (first frame after rst is INIT). Memory contents are not reset.
//  - advance = !out_valid || out_ready; pix_ready = advance.
//    When advance=0, all stages and the RAM read register hold.
//  - Pipeline: S0 accept, issue RAM read at idx. S1 read data, d=(x<<FRAC)-mean
//    (signed MW+1), dsq=(d*d)>>FRAC sat to VW. S2 update, compare, RAM write, load outputs.
//    Latency 3 advancing cycles accept->out_valid. Throughput 1 pixel/clk.
//  - Same-address RAW cannot occur: DEPTH >= 4 > write-back distance.
//  - idx: increments per accepted pixel, wraps W*H-1 -> 0.
//    Accepted pix_sof forces idx 0 for that pixel; if idx!=0 then, set sync_err.
//  - Frame mode is latched at the accepted pixel with idx 0; mid-frame changes are ignored.
//    Effective mode = INIT if init_pending or mode==2; clear init_pending at that latch.
//  - clear: sets init_pending; takes effect at the next frame start, never mid-frame.
//  - INIT: mean=x<<FRAC, var=VAR_INIT, fg=0. Warm-up counter reset to 0 at frame end.
//  - LEARN: mean+=d>>>ALPHA_SHIFT. var+=(dsq-var)>>>ALPHA_SHIFT, clamp [VAR_MIN, 2^VW-1].
//  - FREEZE: no RAM write; outputs show the stored model; fg computed.
//  - fg_c = dsq > K_SQ*var_old (unsigned, full width, no truncation).
//    out_fg forced 0 during INIT frames and while warm-up counter < WARMUP_FRAMES.
//    Warm-up counter saturates; increments at end of each LEARN/FREEZE frame.
//  - Arithmetic shifts floor toward -inf.
//  - rst mid-frame: pipeline flushed, out_valid 0 on next cycle; any write in flight
//    that cycle is dropped.
// STRUCTURE
//  - bgm_pkg: mode enum, MW/VW/word-width functions, channel pack/unpack helpers.
//  - Sub-module bgm_pixel_ram: simple dual-port, 1-cycle read with read-enable (hold on
//    stall). Depth W*H, width NUM_CH*(MW+VW).
//  - Top: idx/frame control, 3-stage datapath via generate loop over NUM_CH.
// TESTING (bench: W=H=2, NUM_CH=3, FRAC=8, ALPHA_SHIFT=3, defaults otherwise)
//  1. rst, frame all 100 -> out_mean=25600 each ch, out_var=4096, out_fg=0, idx 0..3.
//  2. next frame LEARN, pix0=108 -> mean 25856, var 5632, fg=0 (warm-up).
//  3. LEARN frame all 100, then pix0=200 -> dsq=2560000 > 9*var -> out_fg=1.
//  4. FREEZE, pix0=200 for 3 frames -> mean unchanged each frame, out_fg=1 each frame.
//  5. out_ready low 5 cycles mid-frame -> pix_ready low, outputs held, no loss/dup;
//     results bit-identical to unstalled run.
//  6. pix_sof at idx 2 -> sync_err=1 sticky, that pixel out_idx=0.
//     Then rst mid-frame -> out_valid=0 next clk, next frame INIT (var=4096).

Source files
------------

// File: rtl/bgm_pkg.sv
// Shared types and helpers for the EMA background model.
// Mode encoding, word-width functions and channel slicing helpers.
package bgm_pkg;

    typedef enum logic [1:0] {
        MODE_LEARN  = 2'd0,
        MODE_FREEZE = 2'd1,
        MODE_INIT   = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_t;

    // Mean is Q8.FRAC, variance is Q16.FRAC.
    function automatic int mean_w(input int frac);
        return 8 + frac;
    endfunction

    function automatic int var_w(input int frac);
        return 16 + frac;
    endfunction

    function automatic int word_w(input int frac);
        return mean_w(frac) + var_w(frac);
    endfunction

    // Low bit of channel c in a vector packed with w bits per channel.
    function automatic int ch_lo(input int c, input int w);
        return c * w;
    endfunction

    // Mode a frame runs in, given the requested mode and pending INIT.
    // The reserved encoding behaves as LEARN.
    function automatic mode_t eff_mode(input logic [1:0] m, input logic init_pending);
        if (init_pending || m == MODE_INIT)
            return MODE_INIT;
        if (m == MODE_FREEZE)
            return MODE_FREEZE;
        return MODE_LEARN;
    endfunction

endpackage

// File: rtl/bgm_pixel_ram.sv
// Simple dual-port model RAM, one word per pixel, 1-cycle registered read.
// Ports: clk; rd_en/rd_addr/rd_data (read holds while rd_en=0); wr_en/wr_addr/wr_data.
module bgm_pixel_ram #(
    parameter int DEPTH = 4,
    parameter int DW    = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/background_model_ema.sv
// Streaming per-pixel EMA background model with fg/bg classification.
// Ports: clk, rst (sync, active-high); pixel in: pix_valid/pix_ready/pix_data/pix_sof;
// control: mode, clear; result out: out_valid/out_ready/out_mean/out_var/out_fg/out_idx;
// status: sync_err (sticky until rst).
module background_model_ema
    import bgm_pkg::*;
#(
    parameter int WIDTH         = 320,
    parameter int HEIGHT        = 240,
    parameter int NUM_CH        = 3,
    parameter int FRAC          = 8,
    parameter int ALPHA_SHIFT   = 3,
    parameter int K_SQ          = 9,
    parameter int VAR_INIT      = 4096,
    parameter int VAR_MIN       = 256,
    parameter int WARMUP_FRAMES = 1,
    localparam int MW = mean_w(FRAC),
    localparam int VW = var_w(FRAC),
    localparam int IW = $clog2(WIDTH * HEIGHT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic [NUM_CH*8-1:0]  pix_data,
    input  logic                 pix_sof,
    input  logic [1:0]           mode,
    input  logic                 clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUM_CH*MW-1:0] out_mean,
    output logic [NUM_CH*VW-1:0] out_var,
    output logic                 out_fg,
    output logic [IW-1:0]        out_idx,
    output logic                 sync_err
);

    localparam int DEPTH = WIDTH * HEIGHT;
    localparam int CW    = word_w(FRAC);
    localparam int DW    = NUM_CH * CW;
    localparam int DDW   = MW + 1;
    localparam int WCW   = $clog2(WARMUP_FRAMES + 1) + 1;
    localparam int KW    = $clog2(K_SQ + 1) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    if (DEPTH < 4) begin : g_depth_chk
        $error("background_model_ema: WIDTH*HEIGHT must be >= 4");
    end

    // ---------------- S0: accept, frame control, RAM read ----------------
    logic           advance, accept, fg_en;
    logic [IW-1:0]  idx, cur_idx;
    mode_t          cur_mode, frame_mode_q;
    logic           init_pending;
    logic [WCW-1:0] warm_cnt;

    assign advance   = !out_valid || out_ready;
    assign pix_ready = advance;
    assign accept    = pix_valid && advance;
    assign cur_idx   = pix_sof ? '0 : idx;
    assign cur_mode  = (cur_idx == '0) ? eff_mode(mode, init_pending) : frame_mode_q;
    assign fg_en     = (cur_mode != MODE_INIT) && (warm_cnt >= WCW'(WARMUP_FRAMES));

    always_ff @(posedge clk) begin
        if (rst) begin
            idx          <= '0;
            sync_err     <= 1'b0;
            init_pending <= 1'b1;
            warm_cnt     <= '0;
            frame_mode_q <= MODE_INIT;
        end else begin
            if (clear)
                init_pending <= 1'b1;
            if (accept) begin
                idx <= (cur_idx == LAST_IDX) ? '0 : cur_idx + 1'b1;
                if (pix_sof && idx != '0)
                    sync_err <= 1'b1;
                if (cur_idx == '0) begin
                    frame_mode_q <= cur_mode;
                    // a clear landing on a frame start is kept for the next frame
                    if (!clear)
                        init_pending <= 1'b0;
                end
                if (cur_idx == LAST_IDX) begin
                    if (cur_mode == MODE_INIT)
                        warm_cnt <= '0;
                    else if (warm_cnt < WCW'(WARMUP_FRAMES))
                        warm_cnt <= warm_cnt + 1'b1;
                end
            end
        end
    end

    logic [DW-1:0] rd_data, wr_word;
    logic          wr_en;

    // ---------------- S1: difference and squared difference ----------------
    logic                s1_valid, s1_fg_en;
    logic [NUM_CH*8-1:0] s1_x;
    logic [IW-1:0]       s1_idx;
    mode_t               s1_mode;
    logic [NUM_CH*DDW-1:0] s1_d;
    logic [NUM_CH*VW-1:0]  s1_dsq;

    // ---------------- S2: update, compare, write-back ----------------
    logic                  s2_valid, s2_fg_en;
    logic [NUM_CH*8-1:0]   s2_x;
    logic [IW-1:0]         s2_idx;
    mode_t                 s2_mode;
    logic [DW-1:0]         s2_word;
    logic [NUM_CH*DDW-1:0] s2_d;
    logic [NUM_CH*VW-1:0]  s2_dsq;
    logic [NUM_CH*MW-1:0]  nxt_mean;
    logic [NUM_CH*VW-1:0]  nxt_var;
    logic [NUM_CH-1:0]     fg_vec;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam int WL = ch_lo(c, CW);

        // S1 arithmetic
        logic [7:0]             x1;
        logic [MW-1:0]          m1;
        logic signed [MW:0]     d1;
        logic signed [2*MW+1:0] prod;
        logic [2*MW+1:0]        sh;

        assign x1   = s1_x[ch_lo(c, 8) +: 8];
        assign m1   = rd_data[WL +: MW];
        assign d1   = $signed({1'b0, x1, {FRAC{1'b0}}}) - $signed({1'b0, m1});
        assign prod = d1 * d1;
        assign sh   = $unsigned(prod) >> FRAC;
        assign s1_d[ch_lo(c, DDW) +: DDW] = d1;
        assign s1_dsq[ch_lo(c, VW) +: VW] =
            (|sh[2*MW+1:VW]) ? {VW{1'b1}} : sh[VW-1:0];

        // S2 arithmetic
        logic [7:0]             x2;
        logic [MW-1:0]          m_old, m_learn, m_new;
        logic [VW-1:0]          v_old, v_learn, v_new, dsq;
        logic signed [MW:0]     d2, d_sh;
        logic signed [MW+1:0]   m_sum;
        logic signed [VW+1:0]   v_diff, v_step;
        logic signed [VW+2:0]   v_sum;
        logic [VW+KW-1:0]       thr;

        assign x2     = s2_x[ch_lo(c, 8) +: 8];
        assign m_old  = s2_word[WL +: MW];
        assign v_old  = s2_word[WL + MW +: VW];
        assign d2     = s2_d[ch_lo(c, DDW) +: DDW];
        assign dsq    = s2_dsq[ch_lo(c, VW) +: VW];
        assign d_sh   = d2 >>> ALPHA_SHIFT;
        assign m_sum  = $signed({2'b00, m_old}) + $signed({d_sh[MW], d_sh});
        assign v_diff = $signed({2'b00, dsq}) - $signed({2'b00, v_old});
        assign v_step = v_diff >>> ALPHA_SHIFT;
        assign v_sum  = $signed({3'b000, v_old}) + $signed({v_step[VW+1], v_step});
        assign thr    = (VW+KW)'(K_SQ) * {{KW{1'b0}}, v_old};
        assign fg_vec[c] = {{KW{1'b0}}, dsq} > thr;

        always_comb begin
            // the mean stays between old mean and sample; guards are for safety
            if (m_sum[MW+1])
                m_learn = '0;
            else if (m_sum[MW])
                m_learn = '1;
            else
                m_learn = m_sum[MW-1:0];
            if (v_sum < $signed((VW+3)'(VAR_MIN)))
                v_learn = VW'(VAR_MIN);
            else if (v_sum[VW+2:VW] != 3'b000)
                v_learn = '1;
            else
                v_learn = v_sum[VW-1:0];
        end

        always_comb begin
            m_new = m_learn;
            v_new = v_learn;
            case (s2_mode)
                MODE_INIT: begin
                    m_new = {x2, {FRAC{1'b0}}};
                    v_new = VW'(VAR_INIT);
                end
                MODE_FREEZE: begin
                    m_new = m_old;
                    v_new = v_old;
                end
                default: ;
            endcase
        end

        assign nxt_mean[ch_lo(c, MW) +: MW] = m_new;
        assign nxt_var[ch_lo(c, VW) +: VW]  = v_new;
        assign wr_word[WL +: CW]            = {v_new, m_new};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (advance) begin
            s1_valid <= pix_valid;
            s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            s1_x     <= pix_data;
            s1_idx   <= cur_idx;
            s1_mode  <= cur_mode;
            s1_fg_en <= fg_en;
            s2_x     <= s1_x;
            s2_idx   <= s1_idx;
            s2_mode  <= s1_mode;
            s2_fg_en <= s1_fg_en;
            s2_word  <= rd_data;
            s2_d     <= s1_d;
            s2_dsq   <= s1_dsq;
        end
    end

    // write-back is suppressed during rst so an in-flight update is dropped
    assign wr_en = !rst && advance && s2_valid && (s2_mode != MODE_FREEZE);

    bgm_pixel_ram #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (IW)
    ) u_ram (
        .clk     (clk),
        .rd_en   (advance),
        .rd_addr (cur_idx),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (s2_idx),
        .wr_data (wr_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_mean  <= '0;
            out_var   <= '0;
            out_fg    <= 1'b0;
            out_idx   <= '0;
        end else if (advance) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_mean <= nxt_mean;
                out_var  <= nxt_var;
                out_fg   <= s2_fg_en && (|fg_vec);
                out_idx  <= s2_idx;
            end
        end
    end

endmodule
